// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared state encodings and constants for the MSI interrupt scheduler
package irq_sched_pkg;
  localparam int MSI_VEC_W   = 8;
  localparam int DEF_HOLDOFF = 100;
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ASSERT  = 3'b010,
    HOLDOFF = 3'b100
  } state_t;
endpackage

// File: rtl/irq_sched_if.sv
// irq_sched_if: collapser request/ack lines plus the PCIe endpoint cfg_interrupt handshake
interface irq_sched_if #(parameter int NREQ = 2);
  import irq_sched_pkg::*;
  logic [NREQ-1:0]      req_data_rdy;
  logic [NREQ-1:0]      req_data_rdy_ack;
  logic                 cfg_interrupt_msienable;
  logic                 cfg_interrupt_n;
  logic                 cfg_interrupt_rdy_n;
  logic [MSI_VEC_W-1:0] cfg_interrupt_di;
  modport master (
    input  req_data_rdy, cfg_interrupt_msienable, cfg_interrupt_rdy_n,
    output req_data_rdy_ack, cfg_interrupt_n, cfg_interrupt_di
  );
  modport slave (
    output req_data_rdy, cfg_interrupt_msienable, cfg_interrupt_rdy_n,
    input  req_data_rdy_ack, cfg_interrupt_n, cfg_interrupt_di
  );
endinterface

// File: rtl/irq_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_grant_valid,
  output logic [IW-1:0]   o_grant_idx
);
  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = '0;
    // scan farthest-first so the closest index to ptr is the last one written
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % NREQ]) o_grant_idx = IW'((int'(i_ptr) + k) % NREQ);
  end
endmodule

// File: rtl/irq_sched.sv
// irq_sched: coalesces collapser requests into pending bits and issues moderated MSIs round-robin
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int HOLDOFF_W = 16,
  parameter int VEC_BASE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  irq_sched_if.master          bus,
  input  logic                 irq_en,
  input  logic [HOLDOFF_W-1:0] irq_holdoff,
  output logic [NREQ-1:0]      pending
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t               r_state, w_state;
  logic [NREQ-1:0]      r_ack, r_pend, w_cap, w_clr;
  logic [IW-1:0]        r_ptr, w_ptr, r_win, w_win, w_gidx;
  logic                 w_gvld;
  logic                 r_int_n, w_int_n;
  logic [MSI_VEC_W-1:0] r_di, w_di;
  logic [HOLDOFF_W-1:0] r_cnt, w_cnt;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req        (r_pend),
    .i_ptr        (r_ptr),
    .o_grant_valid(w_gvld),
    .o_grant_idx  (w_gidx)
  );

  assign w_cap = bus.req_data_rdy & ~r_ack;

  always_comb begin
    w_state = r_state;
    w_int_n = r_int_n;
    w_di    = r_di;
    w_ptr   = r_ptr;
    w_win   = r_win;
    w_cnt   = r_cnt;
    w_clr   = '0;
    case (r_state)
      IDLE: if (irq_en && bus.cfg_interrupt_msienable && w_gvld) begin
        w_state = ASSERT;
        w_int_n = 1'b0;
        w_win   = w_gidx;
        w_di    = MSI_VEC_W'(VEC_BASE + int'(w_gidx));
      end
      ASSERT: if (!bus.cfg_interrupt_rdy_n) begin
        w_state      = HOLDOFF;
        w_int_n      = 1'b1;
        w_clr[r_win] = 1'b1;
        w_ptr        = IW'((int'(r_win) + 1) % NREQ);
        w_cnt        = irq_holdoff;
      end
      HOLDOFF: if (r_cnt == '0) w_state = IDLE; else w_cnt = r_cnt - 1'b1;
      default: w_state = IDLE;
    endcase
  end

  // capture is OR'ed in after the clear so a same-cycle re-request stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_int_n <= 1'b1;
      r_di    <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state;
      r_int_n <= w_int_n;
      r_di    <= w_di;
      r_ptr   <= w_ptr;
      r_win   <= w_win;
      r_cnt   <= w_cnt;
      r_ack   <= w_cap;
      r_pend  <= (r_pend & ~w_clr) | w_cap;
    end
  end

  assign bus.req_data_rdy_ack = r_ack;
  assign bus.cfg_interrupt_n  = r_int_n;
  assign bus.cfg_interrupt_di = r_di;
  assign pending              = r_pend;
endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: directed scenarios with a timestamp-based reference model checked every cycle
module tb_irq_sched;
  localparam int NREQ = 2, HW = 16, VB = 0;
  logic            clk = 0, rst = 1, irq_en = 1;
  logic [HW-1:0]   holdoff = '0;
  logic [NREQ-1:0] pend;
  int checks = 0, errors = 0;
  int fire[NREQ] = '{default: 0};
  int done[NREQ] = '{default: 0};
  int ep_lat = 3, ep_cnt = 0;
  bit ep_hold = 0;

  irq_sched_if #(.NREQ(NREQ)) bus ();
  irq_sched #(.NREQ(NREQ), .HOLDOFF_W(HW), .VEC_BASE(VB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .irq_en(irq_en), .irq_holdoff(holdoff), .pending(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_lvl(input logic lvl, input int bound);
    int t = 0;
    while (bus.cfg_interrupt_n !== lvl && t < bound) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.cfg_interrupt_n !== lvl) begin
      errors++;
      $display("FAIL wait_cfg_n: got %b expected %b within %0d cycles", bus.cfg_interrupt_n, lvl, bound);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
  endtask

  // collapser: raise data_rdy per queued event, drop on ack
  initial begin
    bus.req_data_rdy = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (bus.req_data_rdy_ack[i]) bus.req_data_rdy[i] = 1'b0;
        else if (!bus.req_data_rdy[i] && fire[i] > done[i]) begin
          bus.req_data_rdy[i] = 1'b1;
          done[i]++;
        end
    end
  end

  // endpoint: answers ep_lat cycles after seeing the request unless held off
  initial begin
    bus.cfg_interrupt_rdy_n = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rst || bus.cfg_interrupt_n) begin
        ep_cnt = 0;
        bus.cfg_interrupt_rdy_n = 1'b1;
      end else begin
        bus.cfg_interrupt_rdy_n = !(!ep_hold && ep_cnt >= ep_lat);
        ep_cnt++;
      end
    end
  end

  // reference model: outstanding flag plus the earliest cycle a new MSI may be issued
  logic [NREQ-1:0] m_ack = '0, m_pend = '0;
  logic            m_n = 1;
  logic [7:0]      m_di = '0;
  int m_ptr = 0, m_w = 0, m_next = 0, cyc = 0;
  bit m_out = 0, m_valid = 0;

  task automatic model_step();
    logic [NREQ-1:0] cap, clr;
    int k;
    if (rst) begin
      m_ack = '0; m_pend = '0; m_n = 1; m_di = '0;
      m_ptr = 0; m_out = 0; m_next = 0; m_valid = 1;
    end else begin
      cap = bus.req_data_rdy & ~m_ack;
      clr = '0;
      if (m_out) begin
        if (!bus.cfg_interrupt_rdy_n) begin
          m_out = 0; m_n = 1; clr[m_w] = 1'b1;
          m_ptr = (m_w + 1) % NREQ;
          m_next = cyc + int'(holdoff) + 2;
        end
      end else if (cyc >= m_next && irq_en && bus.cfg_interrupt_msienable && m_pend != '0) begin
        k = 0;
        while (!m_pend[(m_ptr + k) % NREQ]) k++;
        m_w = (m_ptr + k) % NREQ;
        m_out = 1; m_n = 0; m_di = 8'(VB + m_w);
      end
      m_pend = (m_pend & ~clr) | cap;
      m_ack = cap;
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("cfg_n", 32'(bus.cfg_interrupt_n), 32'(m_n));
      chk("di", 32'(bus.cfg_interrupt_di), 32'(m_di));
      chk("ack", 32'(bus.req_data_rdy_ack), 32'(m_ack));
      chk("pending", 32'(pend), 32'(m_pend));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, acks, lows, msis, bad;
    logic prev_n;
    logic [7:0] d0;
    bus.cfg_interrupt_msienable = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cfg_n", 32'(bus.cfg_interrupt_n), 1);
    chk("rst_di", 32'(bus.cfg_interrupt_di), 0);
    chk("rst_ack", 32'(bus.req_data_rdy_ack), 0);
    chk("rst_pend", 32'(pend), 0);
    rst = 0;
    // single request, endpoint slow to answer
    @(negedge clk) fire[0]++;
    @(negedge clk); chk("t1_ack_early", 32'(bus.req_data_rdy_ack[0]), 0);
    @(negedge clk); chk("t1_ack", 32'(bus.req_data_rdy_ack[0]), 1); chk("t1_pend", 32'(pend), 1);
    @(negedge clk);
    chk("t1_ack_once", 32'(bus.req_data_rdy_ack[0]), 0);
    chk("t1_n_low", 32'(bus.cfg_interrupt_n), 0);
    chk("t1_di", 32'(bus.cfg_interrupt_di), 0);
    repeat (3) @(negedge clk);
    chk("t1_n_hold", 32'(bus.cfg_interrupt_n), 0);
    @(negedge clk);
    chk("t1_n_release", 32'(bus.cfg_interrupt_n), 1);
    chk("t1_pend_clr", 32'(pend), 0);
    // two requests, holdoff spacing and round-robin
    do_reset();
    holdoff = 10; ep_lat = 0;
    @(negedge clk) begin fire[0]++; fire[1]++; end
    wait_lvl(0, 20); t0 = cyc;
    chk("t2_first_di", 32'(bus.cfg_interrupt_di), 0);
    wait_lvl(1, 5); wait_lvl(0, 30);
    chk("t2_spacing", 32'(cyc - t0), 13);
    chk("t2_second_di", 32'(bus.cfg_interrupt_di), 1);
    wait_lvl(1, 5);
    repeat (15) @(negedge clk);
    fire[0]++; fire[1]++;
    wait_lvl(0, 20);
    chk("t2_rr_wrap_di", 32'(bus.cfg_interrupt_di), 0);
    repeat (40) @(negedge clk);
    // disabled: requests coalesce, no MSI until re-enabled
    holdoff = 0; irq_en = 0;
    @(negedge clk) fire[1] += 3;
    acks = 0; lows = 0;
    repeat (12) begin
      @(negedge clk);
      acks += int'(bus.req_data_rdy_ack[1]);
      lows += int'(!bus.cfg_interrupt_n);
    end
    chk("t3_acks", 32'(acks), 3);
    chk("t3_no_irq", 32'(lows), 0);
    chk("t3_pend", 32'(pend), 2);
    irq_en = 1; msis = 0; prev_n = 1; d0 = '0;
    repeat (20) begin
      @(negedge clk);
      if (prev_n && !bus.cfg_interrupt_n) begin msis++; d0 = bus.cfg_interrupt_di; end
      prev_n = bus.cfg_interrupt_n;
    end
    chk("t3_one_msi", 32'(msis), 1);
    chk("t3_msi_di", 32'(d0), 1);
    // irq_en drop during a stalled handshake does not abort it
    ep_hold = 1;
    @(negedge clk) fire[1]++;
    wait_lvl(0, 20);
    d0 = bus.cfg_interrupt_di;
    chk("t4_di", 32'(d0), 1);
    irq_en = 0; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.cfg_interrupt_n !== 1'b0 || bus.cfg_interrupt_di !== d0) bad++;
    end
    chk("t4_held", 32'(bad), 0);
    ep_hold = 0;
    @(negedge clk);
    wait_lvl(1, 5);
    chk("t4_pend_clr", 32'(pend), 0);
    irq_en = 1;
    repeat (5) @(negedge clk);
    // re-request captured in the accept cycle survives the clear
    do_reset();
    holdoff = 4; ep_hold = 1;
    @(negedge clk) fire[0]++;
    wait_lvl(0, 20);
    chk("t5_first_di", 32'(bus.cfg_interrupt_di), 0);
    @(negedge clk) begin fire[0]++; ep_hold = 0; end
    repeat (2) @(negedge clk);
    chk("t5_accepted", 32'(bus.cfg_interrupt_n), 1);
    chk("t5_pend_kept", 32'(pend), 1);
    wait_lvl(0, 20);
    chk("t5_second_di", 32'(bus.cfg_interrupt_di), 0);
    wait_lvl(1, 5);
    repeat (10) @(negedge clk);
    // reset in the middle of a handshake
    ep_hold = 1;
    @(negedge clk) fire[0]++;
    wait_lvl(0, 20);
    rst = 1;
    @(negedge clk);
    chk("t6_cfg_n", 32'(bus.cfg_interrupt_n), 1);
    chk("t6_pend", 32'(pend), 0);
    chk("t6_ack", 32'(bus.req_data_rdy_ack), 0);
    rst = 0; ep_hold = 0;
    repeat (5) @(negedge clk);
    chk("t6_quiet", 32'(bus.cfg_interrupt_n), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
